// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state
// encodings and default widths.
package subtrator_serial_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam int N_DEFAULT  = 8;
    localparam int CW_DEFAULT = 4;

endpackage

// File: rtl/subtrator_serial_completo.sv
// One-bit subtractor cells: a half subtractor and a full subtractor built
// from two half subtractors with the two partial borrows OR-ed together.
module meio_subtrator (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic bout
);

    // Half subtractor: x - y with borrow-out.
    always_comb begin
        diff = x ^ y;
        bout = ~x & y;
    end

endmodule

module subtrator_completo (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic diff_h1;
    logic bout_h1;
    logic bout_h2;

    meio_subtrator u_meio_1 (
        .x    (a),
        .y    (b),
        .diff (diff_h1),
        .bout (bout_h1)
    );

    meio_subtrator u_meio_2 (
        .x    (diff_h1),
        .y    (bin),
        .diff (diff),
        .bout (bout_h2)
    );

    // A borrow is produced by either stage; both can never fire together.
    always_comb begin
        bout = bout_h1 | bout_h2;
    end

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: D = A - B computed LSB first, one bit per
// clock, through a single full-subtractor cell and a borrow flip-flop.
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         borrow
);

    estado_t       estado;
    estado_t       estado_prox;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-2:0]  sres;
    logic [N-1:0]  sres_next;
    logic          bq;
    logic [CW-1:0] cnt;
    logic          diff_bit;
    logic          bout;
    logic          ultimo;

    // The only arithmetic: one full-subtractor cell fed by the operand LSBs.
    subtrator_completo u_celula (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bq),
        .diff (diff_bit),
        .bout (bout)
    );

    // Result register holds the N-1 bits already produced; the bit computed
    // this cycle completes the word on the last edge.
    always_comb begin
        sres_next = {diff_bit, sres};
        ultimo    = (cnt == CW'(N - 1));
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state and status decode; outputs come from the state register only.
    always_comb begin
        estado_prox = estado;
        busy        = 1'b0;
        done        = 1'b0;
        case (estado)
            OCIOSO: begin
                if (start) begin
                    estado_prox = CALCULA;
                end
            end
            CALCULA: begin
                busy = 1'b1;
                if (ultimo) begin
                    estado_prox = FIM;
                end
            end
            FIM: begin
                done        = 1'b1;
                estado_prox = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Operand capture, serial shifting, borrow chain and result commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sres   <= '0;
            bq     <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            borrow <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        bq  <= 1'b0;
                        cnt <= '0;
                    end
                end
                CALCULA: begin
                    sa   <= {1'b0, sa[N-1:1]};
                    sb   <= {1'b0, sb[N-1:1]};
                    sres <= sres_next[N-1:1];
                    bq   <= bout;
                    cnt  <= cnt + 1'b1;
                    // d/borrow are committed on the final edge so they are
                    // already valid in the cycle done is high.
                    if (ultimo) begin
                        d      <= sres_next;
                        borrow <= bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed self-checking bench for the bit-serial subtractor (N = 8).
module tb_subtrator_serial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         borrow;

    int total = 0;
    int bad   = 0;

    subtrator_serial #(.N(N), .CW(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from OCIOSO, wait (bounded) for done, capture the
    // result, then move one more cycle so the DUT is back in OCIOSO.
    task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                         output logic [N-1:0] dv, output logic bwv,
                         output int lat, output int nbusy);
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        nbusy = 0;
        dv = 'x;
        bwv = 1'bx;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = i - 1;
                dv  = d;
                bwv = borrow;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_d: got %h want 00", d); end
        total++; if (borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow: got %b want 0", borrow); end
    endtask

    task automatic test_basic();
        logic [N-1:0] dv;
        logic bwv;
        int lat, nbusy;
        do_op(8'd5, 8'd3, dv, bwv, lat, nbusy);
        total++; if (dv !== 8'h02) begin bad++; $display("FAIL basic_d: got %h want 02", dv); end
        total++; if (bwv !== 1'b0) begin bad++; $display("FAIL basic_borrow: got %b want 0", bwv); end
        total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
        total++; if (nbusy !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 8", nbusy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        total++; if (d !== 8'h02) begin bad++; $display("FAIL basic_d_held: got %h want 02", d); end
    endtask

    task automatic test_wrap();
        logic [N-1:0] va [4] = '{8'd3, 8'h00, 8'hA5, 8'hFF};
        logic [N-1:0] vb [4] = '{8'd5, 8'h01, 8'hA5, 8'h00};
        logic [N-1:0] ed [4] = '{8'hFE, 8'hFF, 8'h00, 8'hFF};
        logic         eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [N-1:0] dv;
        logic bwv;
        int lat, nbusy;
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], dv, bwv, lat, nbusy);
            total++; if (dv !== ed[k]) begin bad++; $display("FAIL wrap_d[%0d]: got %h want %h", k, dv, ed[k]); end
            total++; if (bwv !== eb[k]) begin bad++; $display("FAIL wrap_borrow[%0d]: got %b want %b", k, bwv, eb[k]); end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        logic [N-1:0] dv = 'x;
        logic bwv = 1'bx;
        a = 8'd9;
        b = 8'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        a = 8'hAA;
        b = 8'h55;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ndone++;
                dv  = d;
                bwv = borrow;
            end
            step();
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        total++; if (dv !== 8'd5) begin bad++; $display("FAIL ignore_d: got %h want 05", dv); end
        total++; if (bwv !== 1'b0) begin bad++; $display("FAIL ignore_borrow: got %b want 0", bwv); end
    endtask

    task automatic test_mid_reset();
        int ndone = 0;
        logic [N-1:0] dv;
        logic bwv;
        int lat, nbusy;
        a = 8'd20;
        b = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (d !== 8'h00) begin bad++; $display("FAIL midrst_d: got %h want 00", d); end
        total++; if (borrow !== 1'b0) begin bad++; $display("FAIL midrst_borrow: got %b want 0", borrow); end
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            step();
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", ndone); end
        do_op(8'd20, 8'd7, dv, bwv, lat, nbusy);
        total++; if (dv !== 8'd13) begin bad++; $display("FAIL midrst_retry_d: got %h want 0d", dv); end
        total++; if (bwv !== 1'b0) begin bad++; $display("FAIL midrst_retry_borrow: got %b want 0", bwv); end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int t1 = -1;
        int t2 = -1;
        logic [N-1:0] d1 = 'x;
        logic [N-1:0] d2 = 'x;
        logic b1v = 1'bx;
        logic b2v = 1'bx;
        logic held_ok = 1'b1;
        a = 8'd100;
        b = 8'd30;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) begin
                a = 8'd50;
                b = 8'd80;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = i; d1 = d; b1v = borrow;
                end else if (ndone == 2) begin
                    t2 = i; d2 = d; b2v = borrow;
                end
            end else if (ndone == 1 && d !== 8'd70) begin
                held_ok = 1'b0;
            end
            if (ndone == 1 && busy) start = 1'b0;
        end
        start = 1'b0;
        total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
        total++; if (t2 - t1 !== N + 2) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, N + 2); end
        total++; if (d1 !== 8'd70) begin bad++; $display("FAIL b2b_d1: got %h want 46", d1); end
        total++; if (b1v !== 1'b0) begin bad++; $display("FAIL b2b_borrow1: got %b want 0", b1v); end
        total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL b2b_d1_held: got %b want 1", held_ok); end
        total++; if (d2 !== 8'hE2) begin bad++; $display("FAIL b2b_d2: got %h want e2", d2); end
        total++; if (b2v !== 1'b1) begin bad++; $display("FAIL b2b_borrow2: got %b want 1", b2v); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
